// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port, variable-latency memory between fetch and data ports; data has priority with a fetch starvation guard.
// Latency: request sampled in IDLE -> mem_req next cycle; ready pulse one cycle after mem_ack (N+2+W), or N+1+TIMEOUT on abort.
// Backpressure: one outstanding access; the non-granted requester simply keeps its request high until its own ready pulse.
//
// Ports: clk/rst (async active-low); if_req/if_addr -> if_rdata/if_ready (fetch);
//        dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ready (data);
//        mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack (memory); bus_err flags a timed-out access.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int TIMEOUT      = 64   // 0 disables, 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam bit         TMO_EN   = (TIMEOUT != 0);

    state_t     state;
    logic       grant;        // 0 = fetch, 1 = data
    logic [3:0] starve_cnt;   // data grants issued while fetch was also waiting
    logic [7:0] tmo_cnt;

    // Data wins unless fetch is waiting and has already been passed over LIMIT times.
    logic pick_dm;
    assign pick_dm = dm_req && (!if_req || (starve_cnt < LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            starve_cnt <= 4'd0;
            tmo_cnt    <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            dm_rdata   <= 32'd0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            // Ready and error are single-cycle pulses, only set on the BUSY->RESP edge.
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            bus_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_dm) begin
                        grant     <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // Only count data grants that jumped a waiting fetch; LIMIT check saturates it.
                        starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
                        tmo_cnt   <= 8'd0;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end else if (if_req) begin
                        grant      <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= 32'd0;
                        starve_cnt <= 4'd0;
                        tmo_cnt    <= 8'd0;
                        mem_req    <= 1'b1;
                        state      <= BUSY;
                    end
                end

                BUSY: begin
                    // An ack arriving in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (grant) begin
                            dm_ready <= 1'b1;
                            dm_rdata <= mem_we ? 32'd0 : mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= RESP;
                        if (grant) begin
                            dm_ready <= 1'b1;
                            dm_rdata <= 32'd0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= 32'd0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                RESP: begin
                    // Requests are deliberately not sampled here; the pulse cycle is a dead cycle.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and data-memory port. Accepts one request at a time, holds it on the memory bus until acknowledged or timed out, and returns data with a one-cycle ready pulse. The hazard unit uses the ready pulses to generate StallF/StallD. Arbitration gives the data side priority, with a starvation guard for fetch.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced; range 1–15.
- TIMEOUT, 64: cycles in BUSY without mem_ack before abort; 0 disables the timeout; range 0–255.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high, with address stable, until if_ready.
- if_addr  in  32  fetch word address (pcF).
- if_rdata  out  32  fetch data; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high, with signals stable, until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  data address (ALUResultM).
- dm_wdata  in  32  write data (merged WriteDataM).
- dm_rdata  out  32  read data; valid while dm_ready=1. It is 0 for writes.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request, held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- bus_err  out  1  one-cycle pulse coincident with a ready pulse when the access timed out.

## Operation
- FSM states: IDLE, BUSY, RESP. One outstanding access. Registers: grant (0 = fetch, 1 = data), starve_cnt[3:0], tmo_cnt[7:0].
- **IDLE:**
  - If dm_req and if_req are both high:
    - Grant data if starve_cnt < STARVE_LIMIT, and increment starve_cnt.
    - Otherwise grant fetch, and clear starve_cnt.
  - If only dm_req is high: grant data, and clear starve_cnt.
  - If only if_req is high: grant fetch, and clear starve_cnt.
  - If neither is high: stay in IDLE.
  - On any grant: latch addr, we (forced to 0 for fetch) and wdata into the mem_* output registers; set mem_req=1; clear tmo_cnt; go to BUSY.
- **BUSY:**
  - mem_ack=1: capture mem_rdata into the granted requester's rdata register (write → 0); clear mem_req; go to RESP.
  - Else if TIMEOUT≠0 and tmo_cnt == TIMEOUT−1: clear mem_req; set rdata=0; set bus_err for the RESP cycle; go to RESP.
  - Else increment tmo_cnt.
- **RESP:**
  - Assert the granted side's ready for exactly one cycle; go to IDLE.
  - Requests are not sampled in RESP.
  - A request high in the following IDLE cycle is a new request.
- The non-granted requester's ready stays 0. Its request waits, with no loss.
- mem_ack outside BUSY is ignored.
- mem_ack in the same cycle as the timeout condition: the ack wins, and bus_err=0.
- starve_cnt saturates at STARVE_LIMIT.
- rdata registers hold their last value after ready; consumers use them only while ready=1.

## Timing
- All outputs are registered.
- Reset (rst=0, asynchronous) values: state=IDLE; mem_req, mem_we, if_ready, dm_ready and bus_err = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0; counters = 0.
- Reset mid-access drops mem_req immediately. The access is abandoned with no ready pulse.
- Latency, with the request sampled in cycle N and mem_ack in cycle N+1+W:
  - mem_req is high in cycles N+1 … N+1+W.
  - ready is high in cycle N+2+W.
  - With zero wait states (W=0), ready arrives in N+2.
- Back-to-back accesses: minimum 3 cycles per access (IDLE, BUSY, RESP).
- Timeout abort: ready and bus_err are high in cycle N+1+TIMEOUT.

## Test plan
- **Fetch only, zero-wait memory:** if_req with if_addr=0x0000_0010; mem_ack next cycle with mem_rdata=0x0051_3093 → mem_addr=0x10, mem_we=0, if_ready=1 with if_rdata=0x0051_3093 exactly 2 cycles after sampling; dm_ready stays 0.
- **Simultaneous requests:** dm_req write (addr 0x100, wdata 0xDEAD_BEEF) and if_req together → data is served first (mem_we=1, wdata correct, dm_rdata=0); fetch is granted in the next IDLE; both ready pulses occur exactly once.
- **Starvation guard:** STARVE_LIMIT=4; dm_req held continuously with a new access every ready, and if_req high → grants D,D,D,D,F,D,…; if_ready arrives after the 4th dm_ready.
- **Wait states:** mem_ack delayed 5 cycles with mem_rdata=0x1234_5678 on a data read → mem_req held 6 cycles with stable mem_addr; dm_ready in N+7 with dm_rdata=0x1234_5678.
- **Timeout and reset:** TIMEOUT=8 with no ack → mem_req drops, dm_ready=1, bus_err=1, dm_rdata=0 at N+9. Then a new access with rst pulsed low mid-BUSY → mem_req falls during reset; no ready; FSM in IDLE after release.
